// File: rtl/act_pkg.sv
// Shared Q3.5 constants, datapath widths and packet FSM states for the
// requantizer and the downstream tanh activation stage.
package act_pkg;

  localparam int ACC_W   = 24;
  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 5;
  localparam int OUT_W   = 8;

  // Product of a signed accumulator and an unsigned multiplier needs one extra
  // bit; rounding adds one more so the bias add can never overflow.
  localparam int PROD_W = ACC_W + MULT_W + 1;
  localparam int RND_W  = PROD_W + 1;

  localparam int Q35_MAX       = 127;
  localparam int Q35_MIN       = -128;
  localparam int Q35_FRAC_BITS = 5;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } pkt_state_t;

endpackage

// File: rtl/act_requant_q35_if.sv
// Valid/ready stream bundle between the MAC array, the requantizer and the
// tanh stage, including the per-packet scale configuration.
interface act_requant_q35_if;
  import act_pkg::*;

  logic [MULT_W-1:0]        cfg_mult;
  logic [SHIFT_W-1:0]       cfg_shift;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  in_acc;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last;

  modport master (
    output cfg_mult, cfg_shift, in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cfg_mult, cfg_shift, in_valid, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/act_sat_q35.sv
// Combinational saturator from the 42-bit rounded product to signed Q3.5,
// with a flag raised whenever clamping occurred.
module act_sat_q35
  import act_pkg::*;
(
  input  logic signed [RND_W-1:0] r,
  output logic signed [OUT_W-1:0] q,
  output logic                    sat
);

  localparam logic signed [RND_W-1:0] HI = RND_W'(Q35_MAX);
  localparam logic signed [RND_W-1:0] LO = RND_W'(Q35_MIN);

  always_comb begin
    sat = 1'b1;
    q   = OUT_W'(Q35_MAX);
    if (r > HI) begin
      q = OUT_W'(Q35_MAX);
    end else if (r < LO) begin
      q = OUT_W'(Q35_MIN);
    end else begin
      sat = 1'b0;
      q   = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/act_requant_q35.sv
// Three-stage requantizer: multiply, rounding shift, saturate to Q3.5.
// Define ACT_REQUANT_SAT_CNT_EN to add the sat_clr/sat_count event counter.
module act_requant_q35
  import act_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  act_requant_q35_if.slave    bus,
  output logic                busy
`ifdef ACT_REQUANT_SAT_CNT_EN
  ,
  input  logic                sat_clr,
  output logic [15:0]         sat_count
`endif
);

  pkt_state_t               state;
  logic [MULT_W-1:0]        cfg_mult_q;
  logic [SHIFT_W-1:0]       cfg_shift_q;
  logic [MULT_W-1:0]        eff_mult;
  logic [SHIFT_W-1:0]       eff_shift;

  logic                     s1_valid;
  logic signed [PROD_W-1:0] s1_prod;
  logic [SHIFT_W-1:0]       s1_shift;
  logic                     s1_last;

  logic                     s2_valid;
  logic signed [RND_W-1:0]  s2_r;
  logic                     s2_last;

  logic                     o_valid;
  logic signed [OUT_W-1:0]  o_data;
  logic                     o_last;

  logic signed [RND_W-1:0]  prod_ext;
  logic signed [RND_W-1:0]  bias;
  logic signed [RND_W-1:0]  r_next;
  logic signed [OUT_W-1:0]  sat_q;

  logic en;
  logic accept;

  assign en     = ~o_valid | bus.out_ready;
  assign accept = bus.in_valid & en;

  // A packet's first beat arrives in IDLE and must see this cycle's cfg inputs.
  assign eff_mult  = (state == ST_IDLE) ? bus.cfg_mult  : cfg_mult_q;
  assign eff_shift = (state == ST_IDLE) ? bus.cfg_shift : cfg_shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cfg_mult_q  <= '0;
      cfg_shift_q <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          cfg_mult_q  <= bus.cfg_mult;
          cfg_shift_q <= bus.cfg_shift;
          if (!bus.in_last) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (bus.in_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Zero bias at shift 0 makes the rounded shift collapse to the raw product.
  always_comb begin
    prod_ext = {s1_prod[PROD_W-1], s1_prod};
    bias     = '0;
    if (s1_shift != '0) bias = RND_W'(1) <<< (s1_shift - SHIFT_W'(1));
    r_next   = (prod_ext + bias) >>> s1_shift;
  end

`ifdef ACT_REQUANT_SAT_CNT_EN
  logic sat_next;
  logic o_sat;

  act_sat_q35 u_sat (
    .r   (s2_r),
    .q   (sat_q),
    .sat (sat_next)
  );
`else
  logic sat_unused;

  act_sat_q35 u_sat (
    .r   (s2_r),
    .q   (sat_q),
    .sat (sat_unused)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_last  <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_prod  <= PROD_W'(bus.in_acc) * PROD_W'($signed({1'b0, eff_mult}));
      s1_shift <= eff_shift;
      s1_last  <= bus.in_last;
      s2_valid <= s1_valid;
      s2_r     <= r_next;
      s2_last  <= s1_last;
      o_valid  <= s2_valid;
      o_data   <= sat_q;
      o_last   <= s2_last;
    end
  end

`ifdef ACT_REQUANT_SAT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_sat     <= 1'b0;
      sat_count <= '0;
    end else begin
      if (en) o_sat <= sat_next;
      // Clear has priority over a coincident saturating transfer.
      if (sat_clr) begin
        sat_count <= '0;
      end else if (o_valid && bus.out_ready && o_sat && sat_count != 16'hFFFF) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end
`endif

  assign bus.in_ready  = en;
  assign bus.out_valid = o_valid;
  assign bus.out_data  = o_data;
  assign bus.out_last  = o_last;
  assign busy          = (state == ST_ACTIVE) | s1_valid | s2_valid | o_valid;

endmodule
